monim_sm_capture: RTL and testbench
===================================

// Module: monim_sm_capture
// PURPOSE
//  Parametrised N-channel sample capture stage feeding monim_axil_mon.
//  Registers per-channel data under a per-channel valid, in one of three modes:
//  - LIVE: every valid sample is passed on.
//  - DECIM: every (decim+1)-th sample is passed on.
//  - SNAP: a coherent, all-channel snapshot on request, with a timeout.
//  Keeps a commit counter for the AXI-Lite register map.
// PARAMETERS
//  NCH     2   number of channels (1..16)
//  DW      32  data width per channel
//  DECIM_W 8   decimation ratio width
//  TMO_W   12  snapshot timeout counter width; timeout = 2**TMO_W-1 cycles
// PORTS
//  clk_i        in   1        clock
//  arst_i       in   1        reset; asynchronous, active-high
//  data_i       in   NCH*DW   channel data; ch k at [k*DW +: DW]
//  data_vld_i   in   NCH      per-channel sample valid
//  mode_i       in   2        0 LIVE, 1 DECIM, 2 SNAP, 3 reserved (treated as LIVE)
//  decim_i      in   DECIM_W  decimation ratio minus one
//  snap_req_i   in   1        snapshot request pulse (SNAP mode only)
//  clr_i        in   1        clear counter and min/max
//  p_sm_o       out  NCH*DW   committed channel values
//  p_vld_o      out  1        1-cycle pulse on every commit
//  snap_done_o  out  1        1-cycle pulse when a snapshot commits
//  p_stale_o    out  NCH      channels not refreshed by last snapshot (timeout)
//  busy_o       out  1        snapshot armed
//  smp_cnt_o    out  32       number of commits, wraps 2**32-1 -> 0
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; decim and timeout counters 0; shadow regs and capture mask 0.
//  LIVE:
//  - Channel k with data_vld_i[k]=1 writes p_sm_o[k] at the next edge (1-cycle latency).
//  - Channels without valid hold their value.
//  - p_vld_o pulses if any valid was present; smp_cnt_o +1 per commit cycle.
//  DECIM:
//  - dcnt advances on cycles with any valid.
//  - When dcnt==decim_i: commit as in LIVE, then dcnt<=0. Otherwise dcnt+1, no commit.
//  - decim_i=0 behaves exactly as LIVE.
//  - decim_i lowered below dcnt: commit on next valid, dcnt<=0.
//  SNAP: outputs hold; FSM IDLE/ARMED:
//  - IDLE: snap_req_i=1 -> ARMED; mask<=0, tmo<=0, busy_o=1.
//  - ARMED: ch k with valid and mask[k]=0 -> shadow[k]<=data, mask[k]<=1. Later samples of that channel are ignored.
//  - mask all ones (incl. same-cycle completion): commit all shadows to p_sm_o at once.
//    p_stale_o<=0; p_vld_o, snap_done_o pulse; smp_cnt_o +1; -> IDLE.
//  - tmo reaches 2**TMO_W-1: commit only masked channels; p_stale_o<=~mask; pulses as above; -> IDLE.
//  - snap_req_i while ARMED is ignored. snap_req_i outside SNAP mode is ignored.
//  Mode change (mode_i differs from its registered copy):
//  - Aborts ARMED -> IDLE; no commit; busy_o<=0; dcnt<=0.
//  - Takes effect on the cycle after the change.
//  clr_i:
//  - smp_cnt_o<=0; has priority over a same-cycle increment.
//  - Does not affect p_sm_o or the FSM.
//  Async reset mid-snapshot: FSM to IDLE immediately; shadow data is discarded.
// CONFIGURATION
//  MONIM_SM_MINMAX_EN defined:
//  - Adds outputs ch_min_o and ch_max_o [NCH*DW], signed compare.
//  - Updated per channel on every commit of that channel.
//  - First commit after reset or clr_i loads both with the value.
//  - Reset value 0.
//  MONIM_SM_MINMAX_EN undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  Shared package monim_pkg:
//  - mode_e enum (MODE_LIVE, MODE_DECIM, MODE_SNAP)
//  - snap_state_e (SNAP_IDLE, SNAP_ARMED)
//  - SMP_CNT_W=32 constant
//  Sub-module monim_sm_chan, one per channel (generate loop).
//  - Holds output reg, shadow reg, mask bit and optional min/max.
//  - Driven by commit/capture strobes from the top-level FSM.
//  Top level holds the FSM, decim/timeout counters and smp_cnt.
// TESTING
//  1 LIVE, NCH=2: vld=2'b01, data ch0=0x11 -> next cycle p_sm_o ch0=0x11, ch1 unchanged;
//    p_vld_o=1; smp_cnt_o=1.
//  2 DECIM, decim_i=3: valid every cycle for 8 cycles -> exactly 2 commits, on the 4th and 8th valid;
//    smp_cnt_o=2.
//  3 SNAP: req; ch0 vld at t+2 (0xA), ch1 vld at t+5 (0xB), then ch0 vld again (0xC)
//    -> one commit at t+6 with ch0=0xA, ch1=0xB; snap_done_o=1; p_stale_o=0.
//  4 SNAP timeout, TMO_W=4: req; only ch0 valid -> commit after 15 cycles;
//    ch1 unchanged; p_stale_o=2'b10.
//  5 Abort: req in SNAP, switch mode_i to LIVE before completion -> busy_o=0, no snap_done_o;
//    LIVE commits resume.
//  6 clr_i together with a commit while smp_cnt_o=0xFFFFFFFF -> smp_cnt_o=0.
//    Without clr_i, the same commit wraps to 0.
//    With MONIM_SM_MINMAX_EN: samples 5, -3, 9 -> min=-3, max=9.

Source files
------------

// File: rtl/monim_pkg.sv
// monim_pkg: shared types and constants for the monim capture/monitor slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package monim_pkg;

  typedef enum logic [1:0] {
    MODE_LIVE  = 2'd0,
    MODE_DECIM = 2'd1,
    MODE_SNAP  = 2'd2
  } mode_e;

  typedef enum logic {
    SNAP_IDLE  = 1'b0,
    SNAP_ARMED = 1'b1
  } snap_state_e;

  localparam int SMP_CNT_W = 32;

  // Raw mode field to operating mode; the reserved encoding runs as LIVE.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_DECIM;
      2'd2:    return MODE_SNAP;
      default: return MODE_LIVE;
    endcase
  endfunction

endpackage

// File: rtl/monim_sm_chan.sv
// monim_sm_chan: one capture channel - output reg, snapshot shadow, mask bit, optional min/max.
// Latency: commit strobe to p_sm_o is one clock; capture into shadow is one clock.
// Backpressure: none; strobes from the parent are obeyed every cycle (min/max with MONIM_SM_MINMAX_EN).
module monim_sm_chan #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic [DW-1:0] data_i,
  input  logic          vld_i,
  input  logic          mask_clr_i,
  input  logic          cap_en_i,
  input  logic          live_commit_i,
  input  logic          snap_commit_i,
`ifdef MONIM_SM_MINMAX_EN
  input  logic          clr_i,
  output logic [DW-1:0] ch_min_o,
  output logic [DW-1:0] ch_max_o,
`endif
  output logic          mask_nxt_o,
  output logic [DW-1:0] p_sm_o
);

  logic [DW-1:0] r_out;
  logic [DW-1:0] r_shadow;
  logic          r_mask;
  logic          w_cap;
  logic          w_commit;
  logic [DW-1:0] w_commit_val;

  // Only the first sample of an armed window is kept; the mask is forwarded
  // including this cycle's capture so the parent sees same-cycle completion.
  assign w_cap      = cap_en_i & vld_i & ~r_mask;
  assign mask_nxt_o = r_mask | w_cap;
  assign p_sm_o     = r_out;

  // Select the value to commit: live sample, or shadow (bypassed if captured this cycle).
  always_comb begin
    w_commit     = (live_commit_i & vld_i) | (snap_commit_i & mask_nxt_o);
    w_commit_val = (live_commit_i | w_cap) ? data_i : r_shadow;
  end

  // Shadow and mask capture during an armed snapshot.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_shadow <= '0;
      r_mask   <= 1'b0;
    end else begin
      if (w_cap) r_shadow <= data_i;
      if (mask_clr_i)  r_mask <= 1'b0;
      else if (w_cap)  r_mask <= 1'b1;
    end
  end

  // Committed output register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)        r_out <= '0;
    else if (w_commit) r_out <= w_commit_val;
  end

`ifdef MONIM_SM_MINMAX_EN
  logic [DW-1:0] r_min;
  logic [DW-1:0] r_max;
  logic          r_mm_init;

  assign ch_min_o = r_min;
  assign ch_max_o = r_max;

  // Signed min/max over committed values; first commit after reset/clear seeds both.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_min     <= '0;
      r_max     <= '0;
      r_mm_init <= 1'b0;
    end else if (clr_i) begin
      r_mm_init <= 1'b0;
    end else if (w_commit) begin
      r_mm_init <= 1'b1;
      if (!r_mm_init) begin
        r_min <= w_commit_val;
        r_max <= w_commit_val;
      end else begin
        if ($signed(w_commit_val) < $signed(r_min)) r_min <= w_commit_val;
        if ($signed(w_commit_val) > $signed(r_max)) r_max <= w_commit_val;
      end
    end
  end
`endif

endmodule

// File: rtl/monim_sm_capture.sv
// monim_sm_capture: N-channel sample capture (LIVE/DECIM/SNAP) with commit counter; MONIM_SM_MINMAX_EN adds min/max.
// Latency: a qualifying input cycle shows on p_sm_o/p_vld_o one clock later.
// Backpressure: none; samples not selected by the current mode are dropped.
module monim_sm_capture
  import monim_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int DW      = 32,
  parameter int DECIM_W = 8,
  parameter int TMO_W   = 12
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic [NCH*DW-1:0]    data_i,
  input  logic [NCH-1:0]       data_vld_i,
  input  logic [1:0]           mode_i,
  input  logic [DECIM_W-1:0]   decim_i,
  input  logic                 snap_req_i,
  input  logic                 clr_i,
  output logic [NCH*DW-1:0]    p_sm_o,
  output logic                 p_vld_o,
  output logic                 snap_done_o,
  output logic [NCH-1:0]       p_stale_o,
  output logic                 busy_o,
`ifdef MONIM_SM_MINMAX_EN
  output logic [NCH*DW-1:0]    ch_min_o,
  output logic [NCH*DW-1:0]    ch_max_o,
`endif
  output logic [SMP_CNT_W-1:0] smp_cnt_o
);

  // The armed window lasts 2**TMO_W-1 cycles: tmo counts 0 .. 2**TMO_W-2 and
  // the timeout fires on the cycle the counter would reach its all-ones value.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  snap_state_e          r_state;
  snap_state_e          w_state_nxt;
  logic [1:0]           r_mode;
  logic [DECIM_W-1:0]   r_dcnt;
  logic [TMO_W-1:0]     r_tmo;
  logic                 r_p_vld;
  logic                 r_snap_done;
  logic [NCH-1:0]       r_stale;
  logic [SMP_CNT_W-1:0] r_smp_cnt;

  mode_e                w_mode;
  logic                 w_mode_chg;
  logic                 w_any_vld;
  logic [NCH-1:0]       w_mask_nxt;
  logic                 w_full;
  logic                 w_tmo_hit;
  logic                 w_cap_en;
  logic                 w_arm;
  logic                 w_live_commit;
  logic                 w_snap_commit;

  // A mode change is acted on only after it has been registered, so the
  // change cycle itself neither commits nor captures.
  assign w_mode     = decode_mode(r_mode);
  assign w_mode_chg = (mode_i != r_mode);
  assign w_any_vld  = |data_vld_i;
  assign w_full     = &w_mask_nxt;
  assign w_tmo_hit  = (r_tmo == TMO_LAST);
  assign w_cap_en   = !w_mode_chg && (r_state == SNAP_ARMED);

  // State register plus the registered copy of mode_i.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= SNAP_IDLE;
      r_mode  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= mode_i;
    end
  end

  // Next state: arm on a SNAP-mode request, leave on completion, timeout or mode change.
  always_comb begin
    w_state_nxt = r_state;
    if (w_mode_chg) begin
      w_state_nxt = SNAP_IDLE;
    end else begin
      case (r_state)
        SNAP_IDLE:  if (w_mode == MODE_SNAP && snap_req_i) w_state_nxt = SNAP_ARMED;
        SNAP_ARMED: if (w_full || w_tmo_hit)               w_state_nxt = SNAP_IDLE;
        default:    w_state_nxt = SNAP_IDLE;
      endcase
    end
  end

  // Outputs/strobes: LIVE/DECIM commits from IDLE, snapshot commit from ARMED.
  always_comb begin
    busy_o        = (r_state == SNAP_ARMED);
    w_arm         = 1'b0;
    w_live_commit = 1'b0;
    w_snap_commit = 1'b0;
    if (!w_mode_chg) begin
      case (r_state)
        SNAP_IDLE: begin
          w_arm         = (w_mode == MODE_SNAP) && snap_req_i;
          w_live_commit = w_any_vld &&
                          ((w_mode == MODE_LIVE) ||
                           (w_mode == MODE_DECIM && r_dcnt >= decim_i));
        end
        SNAP_ARMED: w_snap_commit = w_full || w_tmo_hit;
        default: ;
      endcase
    end
  end

  // Decimation counter: counts valid cycles; ">=" also covers decim_i lowered below the count.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_dcnt <= '0;
    end else if (w_mode_chg) begin
      r_dcnt <= '0;
    end else if (w_mode == MODE_DECIM && r_state == SNAP_IDLE && w_any_vld) begin
      r_dcnt <= (r_dcnt >= decim_i) ? '0 : r_dcnt + DECIM_W'(1);
    end
  end

  // Snapshot timeout counter, restarted on arming.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)        r_tmo <= '0;
    else if (w_arm)    r_tmo <= '0;
    else if (w_cap_en) r_tmo <= r_tmo + TMO_W'(1);
  end

  // Commit pulses, stale flags and the commit counter (clear beats increment).
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_p_vld     <= 1'b0;
      r_snap_done <= 1'b0;
      r_stale     <= '0;
      r_smp_cnt   <= '0;
    end else begin
      r_p_vld     <= w_live_commit | w_snap_commit;
      r_snap_done <= w_snap_commit;
      if (w_snap_commit) r_stale <= w_full ? '0 : ~w_mask_nxt;
      if (clr_i)                              r_smp_cnt <= '0;
      else if (w_live_commit | w_snap_commit) r_smp_cnt <= r_smp_cnt + SMP_CNT_W'(1);
    end
  end

  assign p_vld_o     = r_p_vld;
  assign snap_done_o = r_snap_done;
  assign p_stale_o   = r_stale;
  assign smp_cnt_o   = r_smp_cnt;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    monim_sm_chan #(.DW(DW)) u_chan (
      .clk_i         (clk_i),
      .arst_i        (arst_i),
      .data_i        (data_i[k*DW +: DW]),
      .vld_i         (data_vld_i[k]),
      .mask_clr_i    (w_arm),
      .cap_en_i      (w_cap_en),
      .live_commit_i (w_live_commit),
      .snap_commit_i (w_snap_commit),
`ifdef MONIM_SM_MINMAX_EN
      .clr_i         (clr_i),
      .ch_min_o      (ch_min_o[k*DW +: DW]),
      .ch_max_o      (ch_max_o[k*DW +: DW]),
`endif
      .mask_nxt_o    (w_mask_nxt[k]),
      .p_sm_o        (p_sm_o[k*DW +: DW])
    );
  end

endmodule

// File: tb/tb_monim_sm_capture.sv
// tb_monim_sm_capture: directed and randomized checks of monim_sm_capture against a queue/array model.
// Latency: expects commits one clock after the qualifying input cycle.
// Backpressure: none.
module tb_monim_sm_capture;
  localparam int NCH     = 2;
  localparam int DW      = 32;
  localparam int DECIM_W = 8;
  localparam int TMO_W   = 4;
  localparam int TMO_CYC = (1 << TMO_W) - 1;

  logic                clk_i = 1'b0;
  logic                arst_i;
  logic [NCH*DW-1:0]   data_i;
  logic [NCH-1:0]      data_vld_i;
  logic [1:0]          mode_i;
  logic [DECIM_W-1:0]  decim_i;
  logic                snap_req_i;
  logic                clr_i;
  logic [NCH*DW-1:0]   p_sm_o;
  logic                p_vld_o;
  logic                snap_done_o;
  logic [NCH-1:0]      p_stale_o;
  logic                busy_o;
  logic [31:0]         smp_cnt_o;
`ifdef MONIM_SM_MINMAX_EN
  logic [NCH*DW-1:0]   ch_min_o;
  logic [NCH*DW-1:0]   ch_max_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_sm [NCH];
  logic [31:0]   exp_cnt;

  monim_sm_capture #(.NCH(NCH), .DW(DW), .DECIM_W(DECIM_W), .TMO_W(TMO_W)) dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .data_i      (data_i),
    .data_vld_i  (data_vld_i),
    .mode_i      (mode_i),
    .decim_i     (decim_i),
    .snap_req_i  (snap_req_i),
    .clr_i       (clr_i),
    .p_sm_o      (p_sm_o),
    .p_vld_o     (p_vld_o),
    .snap_done_o (snap_done_o),
    .p_stale_o   (p_stale_o),
    .busy_o      (busy_o),
`ifdef MONIM_SM_MINMAX_EN
    .ch_min_o    (ch_min_o),
    .ch_max_o    (ch_max_o),
`endif
    .smp_cnt_o   (smp_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_idle();
    data_vld_i = '0;
    snap_req_i = 1'b0;
    clr_i      = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode_i = m;
    drive_idle();
    step();
  endtask

  task automatic random_data();
    for (int c = 0; c < NCH; c++) data_i[c*DW +: DW] = $urandom;
  endtask

  function automatic logic [NCH*DW-1:0] exp_pack();
    logic [NCH*DW-1:0] p;
    for (int c = 0; c < NCH; c++) p[c*DW +: DW] = exp_sm[c];
    return p;
  endfunction

  task automatic test_reset();
    arst_i = 1'b1;
    drive_idle();
    mode_i  = 2'd0;
    decim_i = '0;
    data_i  = '0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({p_sm_o, p_vld_o, snap_done_o, p_stale_o, busy_o, smp_cnt_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {p_sm_o, p_vld_o, snap_done_o, p_stale_o, busy_o, smp_cnt_o});
    end
    arst_i = 1'b0;
    step();
    for (int c = 0; c < NCH; c++) exp_sm[c] = '0;
    exp_cnt = '0;
    checks++;
    if ({p_vld_o, smp_cnt_o} !== 33'd0) begin
      errors++;
      $display("FAIL reset_idle: got vld=%b cnt=%h required 0", p_vld_o, smp_cnt_o);
    end
  endtask

  task automatic test_live();
    data_i = {32'h99, 32'h11};
    data_vld_i = 2'b01;
    step();
    exp_sm[0] = 32'h11;
    exp_cnt++;
    checks++;
    if (p_sm_o !== exp_pack() || p_vld_o !== 1'b1 || smp_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL live_first: got sm=%h vld=%b cnt=%0d required sm=%h vld=1 cnt=1", p_sm_o, p_vld_o, smp_cnt_o, exp_pack());
    end
    drive_idle();
    data_i = {32'h55, 32'h66};
    step();
    checks++;
    if (p_sm_o !== exp_pack() || p_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL live_hold: got sm=%h vld=%b required sm=%h vld=0", p_sm_o, p_vld_o, exp_pack());
    end
  endtask

  task automatic test_random_live(input logic [1:0] m, input int n);
    set_mode(m);
    for (int i = 0; i < n; i++) begin
      logic [NCH-1:0] v;
      logic exp_vld;
      v = NCH'($urandom_range(0, (1 << NCH) - 1));
      random_data();
      data_vld_i = v;
      snap_req_i = 1'($urandom_range(0, 1));
      step();
      exp_vld = (v != '0);
      for (int c = 0; c < NCH; c++) if (v[c]) exp_sm[c] = data_i[c*DW +: DW];
      if (exp_vld) exp_cnt++;
      checks++;
      if ({p_vld_o, busy_o, snap_done_o} !== {exp_vld, 2'b00} || p_sm_o !== exp_pack() || smp_cnt_o !== exp_cnt) begin
        errors++;
        $display("FAIL live_rand mode=%0d i=%0d: got vld=%b busy=%b sm=%h cnt=%0d required vld=%b busy=0 sm=%h cnt=%0d",
                 m, i, p_vld_o, busy_o, p_sm_o, smp_cnt_o, exp_vld, exp_pack(), exp_cnt);
      end
    end
    drive_idle();
  endtask

  // One valid cycle in DECIM with the expected commit decision.
  task automatic decim_cycle(input logic exp_commit, input string tag);
    random_data();
    data_vld_i = 2'b11;
    step();
    if (exp_commit) begin
      for (int c = 0; c < NCH; c++) exp_sm[c] = data_i[c*DW +: DW];
      exp_cnt++;
    end
    checks++;
    if (p_vld_o !== exp_commit || p_sm_o !== exp_pack() || smp_cnt_o !== exp_cnt) begin
      errors++;
      $display("FAIL %s: got vld=%b sm=%h cnt=%0d required vld=%b sm=%h cnt=%0d",
               tag, p_vld_o, p_sm_o, smp_cnt_o, exp_commit, exp_pack(), exp_cnt);
    end
  endtask

  task automatic test_decim();
    logic [31:0] cnt0;
    set_mode(2'd1);
    decim_i = 8'd3;
    cnt0 = exp_cnt;
    for (int i = 1; i <= 8; i++) decim_cycle((i % 4) == 0, "decim3");
    checks++;
    if (smp_cnt_o !== cnt0 + 32'd2) begin
      errors++;
      $display("FAIL decim3_count: got %0d required %0d", smp_cnt_o, cnt0 + 32'd2);
    end
    decim_i = 8'd5;
    for (int i = 0; i < 3; i++) decim_cycle(1'b0, "decim5_wait");
    decim_i = 8'd1;
    decim_cycle(1'b1, "decim_lowered");
    decim_i = 8'd0;
    for (int i = 0; i < 3; i++) decim_cycle(1'b1, "decim0_live");
    drive_idle();
  endtask

  task automatic test_random_decim();
    for (int r = 0; r < 4; r++) begin
      int since;
      int ratio;
      set_mode(2'd0);
      set_mode(2'd1);
      ratio   = $urandom_range(0, 4);
      decim_i = DECIM_W'(ratio);
      since   = 0;
      for (int i = 0; i < 25; i++) begin
        logic [NCH-1:0] v;
        logic exp_vld;
        v = NCH'($urandom_range(0, 3));
        random_data();
        data_vld_i = v;
        step();
        exp_vld = 1'b0;
        if (v != '0) begin
          since++;
          if (since == ratio + 1) begin
            exp_vld = 1'b1;
            since   = 0;
            exp_cnt++;
            for (int c = 0; c < NCH; c++) if (v[c]) exp_sm[c] = data_i[c*DW +: DW];
          end
        end
        checks++;
        if (p_vld_o !== exp_vld || p_sm_o !== exp_pack() || smp_cnt_o !== exp_cnt) begin
          errors++;
          $display("FAIL decim_rand r=%0d i=%0d: got vld=%b sm=%h cnt=%0d required vld=%b sm=%h cnt=%0d",
                   ratio, i, p_vld_o, p_sm_o, smp_cnt_o, exp_vld, exp_pack(), exp_cnt);
        end
      end
      drive_idle();
    end
  endtask

  task automatic test_snap();
    set_mode(2'd2);
    snap_req_i = 1'b1;
    step();
    snap_req_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL snap_busy: got %b required 1", busy_o);
    end
    for (int i = 1; i <= 5; i++) begin
      data_vld_i = 2'b00;
      data_i = {32'hEE, 32'hDD};
      if (i == 2) begin data_vld_i = 2'b01; data_i = {32'hEE, 32'hA}; end
      if (i == 4) begin data_vld_i = 2'b01; data_i = {32'hEE, 32'hC}; end
      if (i == 5) begin data_vld_i = 2'b11; data_i = {32'hB, 32'hC};  end
      step();
      if (i < 5) begin
        checks++;
        if (p_vld_o !== 1'b0 || busy_o !== 1'b1) begin
          errors++;
          $display("FAIL snap_wait i=%0d: got vld=%b busy=%b required vld=0 busy=1", i, p_vld_o, busy_o);
        end
      end
    end
    exp_sm[0] = 32'hA;
    exp_sm[1] = 32'hB;
    exp_cnt++;
    checks++;
    if ({p_vld_o, snap_done_o, busy_o} !== 3'b110 || p_stale_o !== 2'b00 || p_sm_o !== exp_pack() || smp_cnt_o !== exp_cnt) begin
      errors++;
      $display("FAIL snap_commit: got vld/done/busy=%b stale=%b sm=%h cnt=%0d required 110 00 %h %0d",
               {p_vld_o, snap_done_o, busy_o}, p_stale_o, p_sm_o, smp_cnt_o, exp_pack(), exp_cnt);
    end
    data_vld_i = 2'b01;
    data_i = {32'hEE, 32'hC};
    step();
    drive_idle();
    checks++;
    if (p_vld_o !== 1'b0 || p_sm_o !== exp_pack()) begin
      errors++;
      $display("FAIL snap_idle_hold: got vld=%b sm=%h required vld=0 sm=%h", p_vld_o, p_sm_o, exp_pack());
    end
  endtask

  task automatic test_timeout();
    set_mode(2'd2);
    snap_req_i = 1'b1;
    step();
    snap_req_i = 1'b0;
    for (int i = 1; i <= TMO_CYC; i++) begin
      data_vld_i = (i == 3) ? 2'b01 : 2'b00;
      data_i = {32'h1234, 32'h77};
      step();
      if (i < TMO_CYC) begin
        checks++;
        if (p_vld_o !== 1'b0) begin
          errors++;
          $display("FAIL tmo_wait i=%0d: got vld=%b required 0", i, p_vld_o);
        end
      end
    end
    exp_sm[0] = 32'h77;
    exp_cnt++;
    checks++;
    if ({p_vld_o, snap_done_o, busy_o} !== 3'b110 || p_stale_o !== 2'b10 || p_sm_o !== exp_pack() || smp_cnt_o !== exp_cnt) begin
      errors++;
      $display("FAIL tmo_commit: got vld/done/busy=%b stale=%b sm=%h cnt=%0d required 110 10 %h %0d",
               {p_vld_o, snap_done_o, busy_o}, p_stale_o, p_sm_o, smp_cnt_o, exp_pack(), exp_cnt);
    end
    drive_idle();
  endtask

  task automatic test_random_snap(input int trials);
    logic [NCH-1:0] vt [TMO_CYC+1];
    logic [DW-1:0]  dt [TMO_CYC+1][NCH];
    int             first [NCH];
    int             rate [NCH];
    int             done;
    logic           full;
    logic [NCH-1:0] stale;
    set_mode(2'd2);
    for (int t = 0; t < trials; t++) begin
      for (int c = 0; c < NCH; c++) rate[c] = $urandom_range(0, 3);
      for (int i = 1; i <= TMO_CYC; i++)
        for (int c = 0; c < NCH; c++) begin
          vt[i][c] = ($urandom_range(0, 7) < rate[c]);
          dt[i][c] = $urandom;
        end
      full = 1'b1;
      done = 0;
      for (int c = 0; c < NCH; c++) begin
        first[c] = 0;
        for (int i = TMO_CYC; i >= 1; i--) if (vt[i][c]) first[c] = i;
        stale[c] = (first[c] == 0);
        if (first[c] == 0) full = 1'b0;
        if (first[c] > done) done = first[c];
      end
      if (!full) done = TMO_CYC;
      snap_req_i = 1'b1;
      step();
      checks++;
      if (busy_o !== 1'b1) begin
        errors++;
        $display("FAIL rsnap_busy t=%0d: got %b required 1", t, busy_o);
      end
      for (int i = 1; i <= done; i++) begin
        data_vld_i = vt[i];
        for (int c = 0; c < NCH; c++) data_i[c*DW +: DW] = dt[i][c];
        snap_req_i = 1'($urandom_range(0, 1));
        step();
        if (i < done) begin
          checks++;
          if (p_vld_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL rsnap_wait t=%0d i=%0d: got vld=%b busy=%b required 0 1", t, i, p_vld_o, busy_o);
          end
        end
      end
      for (int c = 0; c < NCH; c++) if (first[c] != 0) exp_sm[c] = dt[first[c]][c];
      exp_cnt++;
      checks++;
      if ({p_vld_o, snap_done_o, busy_o} !== 3'b110 || p_stale_o !== stale || p_sm_o !== exp_pack() || smp_cnt_o !== exp_cnt) begin
        errors++;
        $display("FAIL rsnap_commit t=%0d done=%0d: got vld/done/busy=%b stale=%b sm=%h cnt=%0d required 110 %b %h %0d",
                 t, done, {p_vld_o, snap_done_o, busy_o}, p_stale_o, p_sm_o, smp_cnt_o, stale, exp_pack(), exp_cnt);
      end
      drive_idle();
      step();
    end
  endtask

  task automatic test_abort();
    int done_seen;
    set_mode(2'd2);
    snap_req_i = 1'b1;
    step();
    snap_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_vld_i = 2'b01;
      random_data();
      step();
    end
    mode_i = 2'd0;
    data_vld_i = 2'b00;
    step();
    checks++;
    if ({busy_o, p_vld_o, snap_done_o} !== 3'b000 || smp_cnt_o !== exp_cnt || p_sm_o !== exp_pack()) begin
      errors++;
      $display("FAIL abort: got busy/vld/done=%b cnt=%0d sm=%h required 000 %0d %h",
               {busy_o, p_vld_o, snap_done_o}, smp_cnt_o, p_sm_o, exp_cnt, exp_pack());
    end
    done_seen = 0;
    for (int i = 0; i < TMO_CYC + 4; i++) begin
      data_vld_i = 2'b11;
      random_data();
      step();
      for (int c = 0; c < NCH; c++) exp_sm[c] = data_i[c*DW +: DW];
      exp_cnt++;
      if (snap_done_o) done_seen++;
    end
    drive_idle();
    checks++;
    if (done_seen != 0 || p_sm_o !== exp_pack() || smp_cnt_o !== exp_cnt) begin
      errors++;
      $display("FAIL abort_resume: got done_pulses=%0d sm=%h cnt=%0d required 0 %h %0d", done_seen, p_sm_o, smp_cnt_o, exp_pack(), exp_cnt);
    end
  endtask

  task automatic test_clr_wrap();
    set_mode(2'd0);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    exp_cnt = '0;
    checks++;
    if (smp_cnt_o !== 32'd0 || p_sm_o !== exp_pack()) begin
      errors++;
      $display("FAIL clr_only: got cnt=%0d sm=%h required 0 %h", smp_cnt_o, p_sm_o, exp_pack());
    end
    force dut.r_smp_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_smp_cnt;
    clr_i = 1'b1;
    data_vld_i = 2'b01;
    data_i = {32'h0, 32'h5A5A};
    step();
    exp_sm[0] = 32'h5A5A;
    checks++;
    if (smp_cnt_o !== 32'd0 || p_vld_o !== 1'b1 || p_sm_o !== exp_pack()) begin
      errors++;
      $display("FAIL clr_with_commit: got cnt=%h vld=%b sm=%h required 0 1 %h", smp_cnt_o, p_vld_o, p_sm_o, exp_pack());
    end
    drive_idle();
    force dut.r_smp_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_smp_cnt;
    data_vld_i = 2'b10;
    data_i = {32'hC3C3, 32'h0};
    step();
    exp_sm[1] = 32'hC3C3;
    checks++;
    if (smp_cnt_o !== 32'd0 || p_vld_o !== 1'b1 || p_sm_o !== exp_pack()) begin
      errors++;
      $display("FAIL cnt_wrap: got cnt=%h vld=%b sm=%h required 0 1 %h", smp_cnt_o, p_vld_o, p_sm_o, exp_pack());
    end
    drive_idle();
    exp_cnt = '0;
  endtask

`ifdef MONIM_SM_MINMAX_EN
  task automatic test_minmax();
    int smp [3];
    smp = '{5, -3, 9};
    set_mode(2'd0);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    exp_cnt = '0;
    for (int i = 0; i < 3; i++) begin
      data_vld_i = 2'b01;
      data_i[DW-1:0] = smp[i];
      step();
      exp_sm[0] = smp[i];
      exp_cnt++;
    end
    drive_idle();
    checks++;
    if (ch_min_o[DW-1:0] !== 32'hFFFF_FFFD || ch_max_o[DW-1:0] !== 32'd9) begin
      errors++;
      $display("FAIL minmax: got min=%h max=%h required fffffffd 00000009", ch_min_o[DW-1:0], ch_max_o[DW-1:0]);
    end
  endtask
`endif

  task automatic test_async_reset();
    set_mode(2'd2);
    snap_req_i = 1'b1;
    step();
    snap_req_i = 1'b0;
    data_vld_i = 2'b01;
    data_i = {32'h0, 32'hBAD};
    step();
    drive_idle();
    #2;
    arst_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || p_sm_o !== '0 || smp_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b sm=%h cnt=%0d required 0 0 0", busy_o, p_sm_o, smp_cnt_o);
    end
    step();
    arst_i = 1'b0;
    for (int c = 0; c < NCH; c++) exp_sm[c] = '0;
    exp_cnt = '0;
    set_mode(2'd2);
    snap_req_i = 1'b1;
    step();
    snap_req_i = 1'b0;
    for (int i = 1; i <= TMO_CYC; i++) begin
      data_vld_i = (i == 2) ? 2'b10 : 2'b00;
      data_i = {32'h4242, 32'h0};
      step();
    end
    exp_sm[1] = 32'h4242;
    exp_cnt++;
    checks++;
    if (p_vld_o !== 1'b1 || p_stale_o !== 2'b01 || p_sm_o !== exp_pack() || smp_cnt_o !== exp_cnt) begin
      errors++;
      $display("FAIL reset_discard: got vld=%b stale=%b sm=%h cnt=%0d required 1 01 %h %0d",
               p_vld_o, p_stale_o, p_sm_o, smp_cnt_o, exp_pack(), exp_cnt);
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_live();
    test_random_live(2'd0, 40);
    test_random_live(2'd3, 20);
    test_decim();
    test_random_decim();
    test_snap();
    test_timeout();
    test_random_snap(12);
    test_abort();
    test_clr_wrap();
`ifdef MONIM_SM_MINMAX_EN
    test_minmax();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
